// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: column drive patterns,
// FSM state encoding, frame classification and the snapshot-to-key mapping.
package keypad_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  // Active-low one-hot column drive, indexed by column number; same rotation
  // as the display digit select.
  localparam logic [NUM_COLS-1:0] COL_PAT [NUM_COLS] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    REL_DB
  } state_t;

  typedef enum logic [1:0] {
    FRAME_EMPTY,
    FRAME_SINGLE,
    FRAME_MULTI
  } frame_kind_t;

  // The snapshot is stored column-major (bit = col*4 + row); the reported key
  // code is row-major (row*4 + col), so the two 2-bit halves swap.
  function automatic logic [KEY_W-1:0] key_of_bit(input logic [3:0] bit_idx);
    return {bit_idx[1:0], bit_idx[3:2]};
  endfunction

endpackage

// File: rtl/matrix_keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs. The reset value is
// chosen by the user so idle lines (e.g. pulled-up rows) read as inactive.
module sync_2ff #(
  parameter int             W         = 4,
  parameter logic [W-1:0]   RESET_VAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Shift the asynchronous input through two flops.
  // NOTE: non-blocking assignments let both flops sample the pre-edge values,
  // giving a true two-stage pipeline instead of a single collapsed flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/matrix_keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, samples the
// synchronized rows at the end of each column slot, classifies each complete
// frame and debounces whole frames before reporting a key press.
module matrix_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       Row_In,
  output logic [3:0]       Col_Out,
  output logic [KEY_W-1:0] Key_Code,
  output logic             Key_Valid,
  output logic             Key_Held
);

  localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [3:0]        row_sync;
  logic [3:0]        row_hits;
  logic [TICK_W-1:0] tick_q;
  logic [1:0]        col_q;
  logic [15:0]       snap_q;
  logic [15:0]       frame;
  logic [4:0]        hit_cnt;
  logic [3:0]        hit_idx;
  logic [KEY_W-1:0]  hit_key;
  frame_kind_t       frame_kind;
  logic              slot_end;
  logic              frame_end;

  state_t            state_q,     state_d;
  logic [KEY_W-1:0]  cand_q,      cand_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [KEY_W-1:0]  key_code_q,  key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q,  key_held_d;

  sync_2ff #(
    .W         (4),
    .RESET_VAL (4'b1111)
  ) u_row_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (Row_In),
    .q_o   (row_sync)
  );

  assign row_hits  = ~row_sync;
  assign slot_end  = (tick_q == TICK_LAST);
  assign frame_end = slot_end && (col_q == 2'd3);

  // Slot timer and column rotation; the column advances exactly on the wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_q <= '0;
      col_q  <= '0;
    end else if (slot_end) begin
      tick_q <= '0;
      col_q  <= col_q + 2'd1;
    end else begin
      tick_q <= tick_q + TICK_W'(1);
    end
  end

  // Capture the settled rows of the current column into the frame snapshot.
  // NOTE: the snapshot is a plain register bank and must be cleared on reset so
  // a partial frame from before the reset can never complete a key.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snap_q <= '0;
    end else if (slot_end) begin
      snap_q[{col_q, 2'b00} +: 4] <= row_hits;
    end
  end

  // Complete frame as seen at the end of column 3 (its own bits are written
  // into the snapshot on this same edge) and classify it.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    frame   = snap_q;
    hit_cnt = '0;
    hit_idx = '0;
    frame[{col_q, 2'b00} +: 4] = row_hits;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (hit_cnt == 5'd0)      frame_kind = FRAME_EMPTY;
    else if (hit_cnt == 5'd1) frame_kind = FRAME_SINGLE;
    else                      frame_kind = FRAME_MULTI;
  end

  assign hit_key = key_of_bit(hit_idx);

  // Debounce state and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Frame-level debounce: decisions are taken only when a frame completes.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_kind == FRAME_SINGLE) begin
            state_d = PRESS_DB;
            cand_d  = hit_key;
            cnt_d   = CNT_ONE;
          end
        end
        PRESS_DB: begin
          if (frame_kind == FRAME_SINGLE) begin
            if (hit_key == cand_q) begin
              if (cnt_q + CNT_ONE == CNT_DONE) begin
                state_d     = PRESSED;
                cnt_d       = '0;
                key_code_d  = cand_q;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end else begin
              cand_d = hit_key;
              cnt_d  = CNT_ONE;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (frame_kind == FRAME_EMPTY) begin
            state_d = REL_DB;
            cnt_d   = CNT_ONE;
          end
        end
        REL_DB: begin
          if (frame_kind == FRAME_EMPTY) begin
            if (cnt_q + CNT_ONE == CNT_DONE) begin
              state_d    = IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign Col_Out   = COL_PAT[col_q];
  assign Key_Code  = key_code_q;
  assign Key_Valid = key_valid_q;
  assign Key_Held  = key_held_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with SCAN_TICKS=4, DEBOUNCE_SCANS=3
// (16-cycle frames). A behavioural keypad pulls a row low while its pressed
// key's column is driven. cyc counts falling edges since the last reset
// release, so cyc == k is the sample point just after rising edge k.
module tb_matrix_keypad_scanner;

  localparam int SCAN_TICKS     = 4;
  localparam int DEBOUNCE_SCANS = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  Row_In;
  logic [3:0]  Col_Out;
  logic [3:0]  Key_Code;
  logic        Key_Valid;
  logic        Key_Held;

  logic [15:0] keys = '0;   // bit index = row*4 + col
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          p_base;

  always #5 CLK = ~CLK;

  matrix_keypad_scanner #(
    .SCAN_TICKS     (SCAN_TICKS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Row_In    (Row_In),
    .Col_Out   (Col_Out),
    .Key_Code  (Key_Code),
    .Key_Valid (Key_Valid),
    .Key_Held  (Key_Held)
  );

  // Keypad: a pressed key connects its row to its column line.
  always_comb begin
    Row_In = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !Col_Out[c]) Row_In[r] = 1'b0;
      end
    end
  end

  // Count every Key_Valid cycle.
  always @(negedge CLK) begin
    if (Key_Valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  initial begin
    // 1: reset values and column rotation
    do_reset(3);
    check("rst_col",   Col_Out,   4'b1110);
    check("rst_valid", Key_Valid, 1'b0);
    check("rst_held",  Key_Held,  1'b0);
    check("rst_code",  Key_Code,  4'h0);
    wait_to(3);  check("col_slot0_end", Col_Out, 4'b1110);
    wait_to(4);  check("col_1", Col_Out, 4'b1101);
    wait_to(8);  check("col_2", Col_Out, 4'b1011);
    wait_to(12); check("col_3", Col_Out, 4'b0111);
    wait_to(16); check("col_wrap", Col_Out, 4'b1110);

    // 2: key 9 (row 2, col 1) held; pulse after the 3rd frame evaluation
    do_reset(3);
    keys   = 16'h0200;
    p_base = pulse_cnt;
    wait_to(47);
    check("k9_early_valid", Key_Valid, 1'b0);
    check("k9_early_held",  Key_Held,  1'b0);
    wait_to(48);
    check("k9_valid", Key_Valid, 1'b1);
    check("k9_code",  Key_Code,  4'h9);
    check("k9_held",  Key_Held,  1'b1);
    wait_to(49);
    check("k9_pulse_len", Key_Valid, 1'b0);
    check("k9_held_after", Key_Held, 1'b1);
    wait_to(208);
    check("k9_hold_pulses", pulse_cnt, p_base + 1);
    check("k9_hold_held",   Key_Held,  1'b1);
    check("k9_hold_code",   Key_Code,  4'h9);

    // 4: one empty frame, one-frame re-press, then a real release
    keys = 16'h0000;
    wait_to(224);
    keys = 16'h0200;
    wait_to(239);
    check("repress_held", Key_Held, 1'b1);
    wait_to(240);
    keys = 16'h0000;
    wait_to(287);
    check("rel_held_before", Key_Held, 1'b1);
    wait_to(288);
    check("rel_held_fall", Key_Held,  1'b0);
    check("rel_code_kept", Key_Code,  4'h9);
    check("rel_valid",     Key_Valid, 1'b0);
    check("rel_pulses",    pulse_cnt, p_base + 1);

    // 6: reset during PRESS_DB (cnt=2) on key 9, key kept pressed
    keys = 16'h0200;
    wait_to(328);
    do_reset(1);
    check("mid_rst_col",   Col_Out,   4'b1110);
    check("mid_rst_valid", Key_Valid, 1'b0);
    check("mid_rst_held",  Key_Held,  1'b0);
    check("mid_rst_code",  Key_Code,  4'h0);
    p_base = pulse_cnt;
    wait_to(47);
    check("mid_rst_no_early", pulse_cnt, p_base);
    check("mid_rst_valid47",  Key_Valid, 1'b0);
    wait_to(48);
    check("mid_rst_pulse", Key_Valid, 1'b1);
    check("mid_rst_code9", Key_Code,  4'h9);
    keys = 16'h0000;
    wait_to(96);
    check("mid_rst_rel_held", Key_Held, 1'b0);

    // 5: keys 0 and 5 together, then key 0 alone
    keys = 16'h0021;
    wait_to(160);
    check("multi_no_pulse", pulse_cnt, p_base + 1);
    check("multi_held",     Key_Held,  1'b0);
    keys = 16'h0001;
    wait_to(207);
    check("k0_early_valid", Key_Valid, 1'b0);
    check("k0_code_before", Key_Code,  4'h9);
    wait_to(208);
    check("k0_valid", Key_Valid, 1'b1);
    check("k0_code",  Key_Code,  4'h0);
    check("k0_held",  Key_Held,  1'b1);

    // 3: bouncing key 9 never reaches three consecutive frames
    keys = 16'h0000;
    do_reset(3);
    p_base = pulse_cnt;
    keys   = 16'h0200;
    wait_to(32);
    keys = 16'h0000;
    wait_to(40);
    check("bounce_held_a", Key_Held, 1'b0);
    wait_to(48);
    keys = 16'h0200;
    wait_to(80);
    keys = 16'h0000;
    check("bounce_held_b", Key_Held, 1'b0);
    wait_to(160);
    check("bounce_pulses", pulse_cnt, p_base);
    check("bounce_held_c", Key_Held,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
